// File: rtl/wb_gpio_ctrl.sv
// Wishbone classic GPIO slave: direction/data registers, synchronised
// pad readback and edge-triggered interrupts with W1C status.
module wb_gpio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             irq_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_edge;
  logic [WIDTH-1:0] irq_status;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] next_status;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdat;
  logic [31:0]      bmask;
  logic [31:0]      rdata;
  logic [2:0]       reg_sel;
  logic             req;
  logic             wr;
  logic             unused_ok;

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];

  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                  {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask = bmask[WIDTH-1:0];
  assign wdat  = wb_dat_i[WIDTH-1:0] & wmask;

  assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i, bmask};

  assign gpio_o  = data_out;
  assign gpio_oe = dir;

  assign sync = sync_q[SYNC_STAGES-1];

  // Edge polarity only selects which transition counts; it never
  // feeds the detector itself, so reprogramming cannot fake a hit.
  assign hit = (irq_edge & sync & ~prev)
             | (~irq_edge & ~sync & prev);

  assign w1c = (wr && reg_sel == 3'd5) ? wdat : '0;
  assign next_status = (irq_status & ~w1c) | hit;

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0] old
  );
    return (old & ~wmask) | wdat;
  endfunction

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata[WIDTH-1:0] = sync;
      3'd1:    rdata[WIDTH-1:0] = data_out;
      3'd2:    rdata[WIDTH-1:0] = dir;
      3'd3:    rdata[WIDTH-1:0] = irq_en;
      3'd4:    rdata[WIDTH-1:0] = irq_edge;
      3'd5:    rdata[WIDTH-1:0] = irq_status;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev <= sync;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_edge   <= '0;
      irq_status <= '0;
      irq_o      <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      wb_ack_o   <= req;
      wb_dat_o   <= req ? rdata : '0;
      irq_status <= next_status;
      irq_o      <= |(next_status & irq_en);
      if (wr) begin
        case (reg_sel)
          3'd1:    data_out <= merge(data_out);
          3'd2:    dir      <= merge(dir);
          3'd3:    irq_en   <= merge(irq_en);
          3'd4:    irq_edge <= merge(irq_edge);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed plus randomized bench for wb_gpio_ctrl against a
// register-map model with a pad-history queue.
module tb_wb_gpio_ctrl;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   adr;
  logic [31:0]  dat_i;
  logic [3:0]   sel;
  logic         we;
  logic         cyc;
  logic         stb;
  logic [31:0]  dat_o;
  logic         ack;
  logic         irq;
  logic [W-1:0] gi;
  logic [W-1:0] go;
  logic [W-1:0] goe;

  int ncmp = 0;
  int nerr = 0;

  logic [W-1:0] m_out, m_dir, m_en, m_edge, m_stat;
  logic         m_irq, m_ack;
  logic [W-1:0] hist[$];
  logic [31:0]  rd;

  wb_gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_i),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .irq_o      (irq),
    .gpio_i     (gi),
    .gpio_o     (go),
    .gpio_oe    (goe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_stat = '0;
    m_irq = 1'b0; m_ack = 1'b0;
    hist = {};
    repeat (S + 1) hist.push_back('0);
  endtask

  // hist[0] is the pad value sampled at the latest edge; the
  // synchronised value lags it by S-1 edges.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    case (a[4:2])
      3'd0: v[W-1:0] = hist[S-1];
      3'd1: v[W-1:0] = m_out;
      3'd2: v[W-1:0] = m_dir;
      3'd3: v[W-1:0] = m_en;
      3'd4: v[W-1:0] = m_edge;
      3'd5: v[W-1:0] = m_stat;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic cycle();
    logic [W-1:0] pad, sy, pv, hitv, w1c, nxt, en_old, msk;
    logic [31:0]  bytem, wv;
    logic         r, req;
    pad = gi;
    r   = rst_n;
    req = cyc & stb & ~m_ack;
    @(posedge clk);
    #1;
    if (!r) begin
      model_reset();
      return;
    end
    sy = hist[S-1];
    pv = hist[S];
    for (int i = 0; i < W; i++)
      hitv[i] = m_edge[i] ? (sy[i] & ~pv[i]) : (~sy[i] & pv[i]);
    for (int b = 0; b < 4; b++)
      bytem[8*b +: 8] = {8{sel[b]}};
    wv     = dat_i & bytem;
    msk    = bytem[W-1:0];
    w1c    = '0;
    en_old = m_en;
    if (req && we) begin
      case (adr[4:2])
        3'd1: m_out  = (m_out  & ~msk) | wv[W-1:0];
        3'd2: m_dir  = (m_dir  & ~msk) | wv[W-1:0];
        3'd3: m_en   = (m_en   & ~msk) | wv[W-1:0];
        3'd4: m_edge = (m_edge & ~msk) | wv[W-1:0];
        3'd5: w1c    = wv[W-1:0];
        default: ;
      endcase
    end
    nxt    = (m_stat & ~w1c) | hitv;
    m_irq  = |(nxt & en_old);
    m_stat = nxt;
    m_ack  = req;
    hist.push_front(pad);
    void'(hist.pop_back());
  endtask

  task automatic pins(input string tag);
    check({tag, "_gpio_o"}, 32'(go), 32'(m_out));
    check({tag, "_gpio_oe"}, 32'(goe), 32'(m_dir));
    check({tag, "_irq"}, 32'(irq), 32'(m_irq));
  endtask

  task automatic bus(input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input string tag);
    logic [31:0] exp;
    exp = model_read(a);
    adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    cycle();
    check({tag, "_ack"}, 32'(ack), 32'(1));
    rd = dat_o;
    if (!w) check({tag, "_rdata"}, dat_o, exp);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cycle();
    check({tag, "_ack_off"}, 32'(ack), 32'(0));
    check({tag, "_dat_off"}, dat_o, 32'(0));
  endtask

  initial begin
    adr = '0; dat_i = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; gi = '0; rst_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_dat", dat_o, 32'(0));
    check("rst_irq", 32'(irq), 32'(0));
    check("rst_oe", 32'(goe), 32'(0));
    check("rst_out", 32'(go), 32'(0));
    rst_n = 1'b1;
    cycle();

    for (int a = 0; a < 6; a++) begin
      bus(1'b0, 5'(a * 4), '0, 4'hF, "t1_read");
      check("t1_zero", rd, 32'(0));
    end

    bus(1'b1, 5'h08, 32'hFF, 4'hF, "t2_dir");
    bus(1'b1, 5'h04, 32'hA5, 4'hF, "t2_out");
    check("t2_oe", 32'(goe), 32'hFF);
    check("t2_o", 32'(go), 32'hA5);
    bus(1'b0, 5'h04, '0, 4'h0, "t2_rd");
    check("t2_rdval", rd, 32'h0000_00A5);

    bus(1'b1, 5'h08, 32'h1234_5678, 4'b0001, "t3_sel");
    bus(1'b0, 5'h08, '0, 4'hF, "t3_rd");
    check("t3_dir", rd, 32'h78);
    bus(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, "t3_w18");
    bus(1'b0, 5'h18, '0, 4'hF, "t3_r18");
    check("t3_r18val", rd, 32'(0));
    bus(1'b0, 5'h08, '0, 4'hF, "t3_rd2");
    check("t3_dir2", rd, 32'h78);
    pins("t3");

    bus(1'b1, 5'h0C, 32'h01, 4'hF, "t4_en");
    bus(1'b1, 5'h10, 32'h01, 4'hF, "t4_edge");
    gi[0] = 1'b1;
    repeat (S) cycle();
    check("t4_irq_early", 32'(irq), 32'(0));
    cycle();
    check("t4_irq_set", 32'(irq), 32'(1));
    bus(1'b0, 5'h14, '0, 4'hF, "t4_rs");
    check("t4_stat", rd, 32'h01);
    bus(1'b1, 5'h14, 32'h01, 4'hF, "t4_w1c");
    check("t4_irq_clr", 32'(irq), 32'(0));
    bus(1'b0, 5'h14, '0, 4'hF, "t4_rs2");
    check("t4_stat_clr", rd, 32'(0));
    gi[0] = 1'b0;
    repeat (S + 3) cycle();
    bus(1'b0, 5'h14, '0, 4'hF, "t4_fall");
    check("t4_nofall", rd, 32'(0));
    check("t4_irq_nofall", 32'(irq), 32'(0));

    gi[3] = 1'b1;
    repeat (S + 3) cycle();
    bus(1'b0, 5'h14, '0, 4'hF, "t5_rs");
    check("t5_norise", rd, 32'(0));
    gi[3] = 1'b0;
    repeat (S) cycle();
    bus(1'b1, 5'h14, 32'h08, 4'hF, "t5_w1c");
    bus(1'b0, 5'h14, '0, 4'hF, "t5_rs2");
    check("t5_setwins", rd, 32'h08);
    bus(1'b1, 5'h14, 32'h08, 4'hF, "t5_w1c2");
    bus(1'b0, 5'h14, '0, 4'hF, "t5_rs3");
    check("t5_cleared", rd, 32'(0));

    adr = 5'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    cycle();
    check("t6_ack_hi", 32'(ack), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t6_ack_async", 32'(ack), 32'(0));
    check("t6_oe_async", 32'(goe), 32'(0));
    model_reset();
    cyc = 1'b0; stb = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    adr = 5'h04; dat_i = 32'h5A; sel = 4'hF; we = 1'b1;
    cyc = 1'b1; stb = 1'b1;
    #2;
    rst_n = 1'b0;
    cycle();
    check("t6_noack", 32'(ack), 32'(0));
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle();
    check("t6_noack2", 32'(ack), 32'(0));
    bus(1'b0, 5'h04, '0, 4'hF, "t6_rd");
    check("t6_out0", rd, 32'(0));

    adr = 5'h04; dat_i = 32'hFF; sel = 4'hF; we = 1'b1;
    cyc = 1'b0; stb = 1'b1;
    cycle();
    check("nocyc_ack", 32'(ack), 32'(0));
    stb = 1'b0; we = 1'b0;
    cycle();
    check("nocyc_out", 32'(go), 32'(0));

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          gi = W'($urandom);
          cycle();
        end
        1: begin
          if ($urandom_range(0, 1) == 1) gi = W'($urandom);
          bus(1'b1, 5'($urandom), $urandom, 4'($urandom), "rnd_wr");
        end
        2: begin
          if ($urandom_range(0, 1) == 1) gi = W'($urandom);
          bus(1'b0, 5'($urandom), $urandom, 4'($urandom), "rnd_rd");
        end
        default: repeat ($urandom_range(1, 4)) cycle();
      endcase
      pins("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
